// File: rtl/pipeline_stall_controller_if.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller_if
//   Bundles the hazard/busy/context-switch inputs and the per-stage register
//   controls exchanged between the pipeline datapath and the stall controller.
//
//   Parameters:
//     STALL_CNT_W      width of the stall performance counter
//
//   Signals (direction as seen by the controller, modport slave):
//     load_use_hazard  in   load-use hazard from the hazard detection unit
//     branch_taken_EX  in   branch/jump resolved taken in EX
//     icache_busy      in   instruction memory not ready
//     dcache_busy      in   data memory not ready
//     cs_req           in   context-switch request from OS control
//     pc_en            out  PC write enable
//     if_id_en         out  IF/ID register enable
//     id_ex_en         out  ID/EX register enable
//     ex_mem_en        out  EX/MEM register enable
//     mem_wb_en        out  MEM/WB register enable
//     if_id_flush      out  load a bubble into IF/ID
//     id_ex_flush      out  load a bubble into ID/EX
//     cs_ack           out  pipeline drained and frozen
//     stall_count      out  saturating count of stalled RUN cycles
//
//   The master modport is the datapath / environment side.
// ---------------------------------------------------------------------------
interface pipeline_stall_controller_if #(
  parameter int STALL_CNT_W = 32
);
  logic                   load_use_hazard;
  logic                   branch_taken_EX;
  logic                   icache_busy;
  logic                   dcache_busy;
  logic                   cs_req;
  logic                   pc_en;
  logic                   if_id_en;
  logic                   id_ex_en;
  logic                   ex_mem_en;
  logic                   mem_wb_en;
  logic                   if_id_flush;
  logic                   id_ex_flush;
  logic                   cs_ack;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output load_use_hazard, branch_taken_EX, icache_busy, dcache_busy, cs_req,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    input  if_id_flush, id_ex_flush, cs_ack, stall_count
  );

  modport slave (
    input  load_use_hazard, branch_taken_EX, icache_busy, dcache_busy, cs_req,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
    output if_id_flush, id_ex_flush, cs_ack, stall_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//   Central stall/flush sequencer for the 5-stage pipeline. Merges load-use,
//   branch redirect and I/D memory busy into per-stage enables and flushes,
//   and drains/freezes the pipeline around an OS context switch using a
//   4-phase cs_req/cs_ack handshake.
//
//   Parameters:
//     DRAIN_CYCLES  forward-progress cycles needed to empty ID..WB
//     STALL_CNT_W   width of the saturating stall counter (must match bus)
//
//   Ports:
//     CLK    clock, rising edge
//     RESET  synchronous, active-low reset
//     bus    controller side of pipeline_stall_controller_if
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int DRAIN_CYCLES = 4,
  parameter int STALL_CNT_W  = 32
) (
  input  logic                           CLK,
  input  logic                           RESET,
  pipeline_stall_controller_if.slave     bus
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HELD  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DRAIN_W-1:0]     drain_cnt_q, drain_cnt_d;
  logic                   cs_ack_q, cs_ack_d;
  logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush;

  // Stage controls: combinational from state and hazard inputs.
  // In RUN/DRAIN the hazards are resolved by fixed priority; DRAIN then
  // suppresses fetch unless the whole pipe is frozen by dcache_busy.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!RESET) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state_q == HELD) begin
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      if (bus.dcache_busy) begin
        // full freeze: every stage holds, nothing is lost
      end else if (bus.branch_taken_EX) begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (bus.load_use_hazard) begin
        // hold IF and ID, push a bubble into EX, let older work drain
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        id_ex_flush = 1'b1;
      end else if (bus.icache_busy) begin
        {if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 4'b1111;
        if_id_flush = 1'b1;
      end else begin
        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
      end
      if (state_q == DRAIN && !bus.dcache_busy) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
    end
  end

  // Sequencer: RUN -> DRAIN on request, count forward-progress cycles
  // (a load-use bubble restarts the count, a dcache freeze pauses it),
  // then HELD with cs_ack until the OS withdraws cs_req.
  always_comb begin
    state_d       = state_q;
    drain_cnt_d   = drain_cnt_q;
    cs_ack_d      = cs_ack_q;
    stall_count_d = stall_count_q;
    case (state_q)
      RUN: begin
        if (!pc_en && !(&stall_count_q)) begin
          stall_count_d = stall_count_q + 1'b1;
        end
        if (bus.cs_req && !bus.dcache_busy) begin
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end
      end
      DRAIN: begin
        if (!bus.dcache_busy) begin
          if (bus.load_use_hazard) begin
            drain_cnt_d = '0;
          end else if (drain_cnt_q == DRAIN_LAST) begin
            state_d     = HELD;
            drain_cnt_d = '0;
            cs_ack_d    = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      HELD: begin
        if (!bus.cs_req) begin
          state_d  = RUN;
          cs_ack_d = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q       <= RUN;
      drain_cnt_q   <= '0;
      cs_ack_q      <= 1'b0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      cs_ack_q      <= cs_ack_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.if_id_en    = if_id_en;
  assign bus.id_ex_en    = id_ex_en;
  assign bus.ex_mem_en   = ex_mem_en;
  assign bus.mem_wb_en   = mem_wb_en;
  assign bus.if_id_flush = if_id_flush;
  assign bus.id_ex_flush = id_ex_flush;
  assign bus.cs_ack      = cs_ack_q;
  assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_controller
//   Self-checking bench for pipeline_stall_controller. A second instance with
//   a 3-bit stall counter shares the same inputs to exercise saturation.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_controller;

  logic CLK = 1'b0;
  logic RESET = 1'b0;

  // 10 ns clock
  always #5 CLK = ~CLK;

  pipeline_stall_controller_if #(.STALL_CNT_W(32)) bus ();
  pipeline_stall_controller_if #(.STALL_CNT_W(3))  bus3 ();

  assign bus3.load_use_hazard = bus.load_use_hazard;
  assign bus3.branch_taken_EX = bus.branch_taken_EX;
  assign bus3.icache_busy     = bus.icache_busy;
  assign bus3.dcache_busy     = bus.dcache_busy;
  assign bus3.cs_req          = bus.cs_req;

  pipeline_stall_controller #(.DRAIN_CYCLES(4), .STALL_CNT_W(32)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  pipeline_stall_controller #(.DRAIN_CYCLES(4), .STALL_CNT_W(3)) dut3 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus3.slave)
  );

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush}
  logic [6:0] ctl_vec;
  assign ctl_vec = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en,
                    bus.mem_wb_en, bus.if_id_flush, bus.id_ex_flush};

  localparam logic [6:0] C_NONE   = 7'b1111100;
  localparam logic [6:0] C_LU     = 7'b0011101;
  localparam logic [6:0] C_BR     = 7'b1111111;
  localparam logic [6:0] C_IC     = 7'b0111110;
  localparam logic [6:0] C_FRZ    = 7'b0000000;
  localparam logic [6:0] C_RST    = 7'b0000011;
  localparam logic [6:0] C_DRN    = 7'b0111110;
  localparam logic [6:0] C_DRN_LU = 7'b0011111;
  localparam logic [6:0] C_HELD   = 7'b0111111;

  typedef struct {
    string      name;
    logic [6:0] ctl;
    logic       ack;
    logic       run;
    logic       rst_n;
  } exp_t;

  typedef struct {
    string      name;
    logic       lu;
    logic       br;
    logic       ic;
    logic       dc;
    logic [6:0] ctl;
  } vec_t;

  exp_t   sb_q[$];
  vec_t   vecs[10];
  int     errors = 0;
  int     checks = 0;
  longint exp_stall = 0;

  // Compare one value and report a mismatch.
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge and queue its expectation.
  task automatic applyStimulus(input string name, input logic rst_n,
                               input logic lu, input logic br, input logic ic,
                               input logic dc, input logic cs,
                               input logic [6:0] ctl, input logic ack, input logic run);
    exp_t e;
    @(posedge CLK);
    #1;
    RESET               = rst_n;
    bus.load_use_hazard = lu;
    bus.branch_taken_EX = br;
    bus.icache_busy     = ic;
    bus.dcache_busy     = dc;
    bus.cs_req          = cs;
    e.name  = name;
    e.ctl   = ctl;
    e.ack   = ack;
    e.run   = run;
    e.rst_n = rst_n;
    sb_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare at the falling edge.
  task automatic checkOutput();
    exp_t   e;
    longint sat;
    @(negedge CLK);
    if (sb_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue expected an entry");
      return;
    end
    e   = sb_q.pop_front();
    sat = (exp_stall > 7) ? 7 : exp_stall;
    check({e.name, "/ctl"}, 64'(ctl_vec), 64'(e.ctl));
    check({e.name, "/ack"}, 64'(bus.cs_ack), 64'(e.ack));
    check({e.name, "/stall"}, 64'(bus.stall_count), 64'(exp_stall));
    check({e.name, "/stall3"}, 64'(bus3.stall_count), 64'(sat));
    if (!e.rst_n) exp_stall = 0;
    else if (e.run && !e.ctl[6]) exp_stall++;
  endtask

  task automatic step(input string name, input logic rst_n,
                      input logic lu, input logic br, input logic ic,
                      input logic dc, input logic cs,
                      input logic [6:0] ctl, input logic ack, input logic run);
    applyStimulus(name, rst_n, lu, br, ic, dc, cs, ctl, ack, run);
    checkOutput();
  endtask

  initial begin
    vecs[0] = '{"none",     1'b0, 1'b0, 1'b0, 1'b0, C_NONE};
    vecs[1] = '{"lu",       1'b1, 1'b0, 1'b0, 1'b0, C_LU};
    vecs[2] = '{"br",       1'b0, 1'b1, 1'b0, 1'b0, C_BR};
    vecs[3] = '{"lu_br",    1'b1, 1'b1, 1'b0, 1'b0, C_BR};
    vecs[4] = '{"ic",       1'b0, 1'b0, 1'b1, 1'b0, C_IC};
    vecs[5] = '{"dc",       1'b0, 1'b0, 1'b0, 1'b1, C_FRZ};
    vecs[6] = '{"dc_br",    1'b0, 1'b1, 1'b0, 1'b1, C_FRZ};
    vecs[7] = '{"ic_lu",    1'b1, 1'b0, 1'b1, 1'b0, C_LU};
    vecs[8] = '{"ic_br",    1'b0, 1'b1, 1'b1, 1'b0, C_BR};
    vecs[9] = '{"all",      1'b1, 1'b1, 1'b1, 1'b1, C_FRZ};

    bus.load_use_hazard = 1'b0;
    bus.branch_taken_EX = 1'b0;
    bus.icache_busy     = 1'b0;
    bus.dcache_busy     = 1'b0;
    bus.cs_req          = 1'b0;

    // Reset state
    step("reset0", 1'b0, 0, 0, 0, 0, 0, C_RST, 1'b0, 1'b0);
    step("reset1", 1'b0, 0, 0, 0, 0, 0, C_RST, 1'b0, 1'b0);

    // Single-cycle RUN priority vectors
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].name, 1'b1, vecs[i].lu, vecs[i].br, vecs[i].ic, vecs[i].dc, 1'b0,
           vecs[i].ctl, 1'b0, 1'b1);
    end

    // dcache freeze masks a pending branch, which appears once busy drops
    for (int i = 0; i < 3; i++) step("frz_br", 1'b1, 0, 1, 0, 1, 0, C_FRZ, 1'b0, 1'b1);
    step("br_after_frz", 1'b1, 0, 1, 0, 0, 0, C_BR, 1'b0, 1'b1);
    step("idle", 1'b1, 0, 0, 0, 0, 0, C_NONE, 1'b0, 1'b1);

    // Clean context switch: 4 drain cycles, HELD ignores hazards, release
    step("cs_req", 1'b1, 0, 0, 0, 0, 1, C_NONE, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("drain", 1'b1, 0, 0, 0, 0, 1, C_DRN, 1'b0, 1'b0);
    step("held_ign", 1'b1, 1, 1, 1, 1, 1, C_HELD, 1'b1, 1'b0);
    step("held_rel", 1'b1, 0, 0, 0, 0, 0, C_HELD, 1'b1, 1'b0);
    step("run_back", 1'b1, 0, 0, 0, 0, 0, C_NONE, 1'b0, 1'b1);

    // Drain restarted by load-use, paused by dcache, cs_req dropped mid-drain
    step("cs_req2", 1'b1, 0, 0, 0, 0, 1, C_NONE, 1'b0, 1'b1);
    step("drn_a", 1'b1, 0, 0, 0, 0, 1, C_DRN, 1'b0, 1'b0);
    step("drn_b", 1'b1, 0, 0, 0, 0, 1, C_DRN, 1'b0, 1'b0);
    step("drn_lu", 1'b1, 1, 0, 0, 0, 1, C_DRN_LU, 1'b0, 1'b0);
    step("drn_dc", 1'b1, 0, 0, 0, 1, 1, C_FRZ, 1'b0, 1'b0);
    step("drn_dc", 1'b1, 0, 0, 0, 1, 1, C_FRZ, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("drn_prog", 1'b1, 0, 0, 0, 0, 0, C_DRN, 1'b0, 1'b0);
    step("held_pulse", 1'b1, 0, 0, 0, 0, 0, C_HELD, 1'b1, 1'b0);
    step("run_back2", 1'b1, 0, 0, 0, 0, 0, C_NONE, 1'b0, 1'b1);

    // Stall counter saturation on the 3-bit instance
    step("reset2", 1'b0, 0, 0, 0, 0, 0, C_RST, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step("sat_ic", 1'b1, 0, 0, 1, 0, 0, C_IC, 1'b0, 1'b1);
    step("sat_end", 1'b1, 0, 0, 0, 0, 0, C_NONE, 1'b0, 1'b1);

    // Reset in the middle of DRAIN
    step("cs_req3", 1'b1, 0, 0, 0, 0, 1, C_NONE, 1'b0, 1'b1);
    step("drn3", 1'b1, 0, 0, 0, 0, 1, C_DRN, 1'b0, 1'b0);
    step("drn3", 1'b1, 0, 0, 0, 0, 1, C_DRN, 1'b0, 1'b0);
    step("rst_drn", 1'b0, 0, 0, 0, 0, 1, C_RST, 1'b0, 1'b0);
    step("after_rst_drn", 1'b1, 0, 0, 0, 0, 0, C_NONE, 1'b0, 1'b1);

    // Reset while HELD clears cs_ack on the reset edge
    step("cs_req4", 1'b1, 0, 0, 0, 0, 1, C_NONE, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("drn4", 1'b1, 0, 0, 0, 0, 1, C_DRN, 1'b0, 1'b0);
    step("held4", 1'b1, 0, 0, 0, 0, 1, C_HELD, 1'b1, 1'b0);
    step("rst_held", 1'b0, 0, 0, 0, 0, 1, C_RST, 1'b1, 1'b0);
    step("after_rst_held", 1'b1, 0, 0, 0, 0, 1, C_NONE, 1'b0, 1'b1);
    step("redrain", 1'b1, 0, 0, 0, 0, 0, C_DRN, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
